// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: runs multi-byte SPI bursts through the SPI master's 3-bit register port,
// keeping slave-select asserted for the whole burst and one byte in flight at a time.
module spi_xfer_sequencer #(
    parameter int          DEPTH      = 16,
    parameter int          AW         = 4,
    parameter int          POLL_LIMIT = 255,
    parameter logic [15:0] SS_MASK    = 16'h0001
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   xfer_len,
    input  logic          tx_wr,
    input  logic [AW-1:0] tx_addr,
    input  logic [7:0]    tx_data,
    input  logic [AW-1:0] rx_addr,
    output logic [7:0]    rx_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err,
    output logic          spi_select,
    output logic [2:0]    spi_mem_addr,
    output logic          spi_read_n,
    output logic          spi_write_n,
    output logic [15:0]   spi_data_from_cpu,
    input  logic [15:0]   spi_data_to_cpu
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        IDLE, SETSS, SSO_ON, POLL_T, WRDATA, POLL_R, RDDATA, POLL_E, SSO_OFF, ERRCLR, FIN
    } state_t;

    state_t        state;
    state_t        after_state;
    logic [1:0]    phase;
    logic [1:0]    after_err;
    logic [AW-1:0] idx;
    logic [AW:0]   len;
    logic [AW:0]   len_clamped;
    logic [PW-1:0] poll_cnt;
    logic          poll_expired;
    logic          last_byte;
    logic          st_e, st_rrdy, st_trdy, st_tmt;
    logic [2:0]    acc_addr;
    logic          acc_wr;
    logic [15:0]   acc_wdata;
    logic          unused_rd_hi;

    logic [7:0] tx_buf [DEPTH];
    logic [7:0] rx_buf [DEPTH];

    assign rx_data      = rx_buf[rx_addr];
    assign len_clamped  = (xfer_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : xfer_len;
    assign last_byte    = ({1'b0, idx} == len - (AW+1)'(1));
    assign poll_expired = (poll_cnt == PW'(POLL_LIMIT - 1));
    assign unused_rd_hi = ^spi_data_to_cpu[15:9];

    always_ff @(posedge clk) begin
        if (tx_wr && !busy) tx_buf[tx_addr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (!reset && state == RDDATA && phase == 2'd1) rx_buf[idx] <= spi_data_to_cpu[7:0];
    end

    // Where the FSM goes once the current access window closes; E beats timeout.
    always_comb begin
        after_state = state;
        after_err   = err;
        case (state)
            IDLE:    if (start && xfer_len != '0) after_state = SETSS;
            SETSS:   after_state = SSO_ON;
            SSO_ON:  after_state = POLL_T;
            POLL_T: begin
                if (st_e) begin
                    after_state = ERRCLR;
                    after_err   = 2'd2;
                end else if (st_trdy) begin
                    after_state = WRDATA;
                end else if (poll_expired) begin
                    after_state = ERRCLR;
                    after_err   = 2'd1;
                end
            end
            WRDATA:  after_state = POLL_R;
            POLL_R: begin
                if (st_e) begin
                    after_state = ERRCLR;
                    after_err   = 2'd2;
                end else if (st_rrdy) begin
                    after_state = RDDATA;
                end else if (poll_expired) begin
                    after_state = ERRCLR;
                    after_err   = 2'd1;
                end
            end
            RDDATA:  after_state = last_byte ? POLL_E : POLL_T;
            POLL_E: begin
                if (st_e) begin
                    after_state = ERRCLR;
                    after_err   = 2'd2;
                end else if (st_tmt) begin
                    after_state = SSO_OFF;
                end else if (poll_expired) begin
                    after_state = ERRCLR;
                    after_err   = 2'd1;
                end
            end
            ERRCLR:  after_state = SSO_OFF;
            SSO_OFF: after_state = FIN;
            default: after_state = state;
        endcase
    end

    always_comb begin
        acc_addr  = 3'd0;
        acc_wr    = 1'b0;
        acc_wdata = 16'h0000;
        case (after_state)
            SETSS:   begin acc_addr = 3'd5; acc_wr = 1'b1; acc_wdata = SS_MASK;  end
            SSO_ON:  begin acc_addr = 3'd3; acc_wr = 1'b1; acc_wdata = 16'h0400; end
            SSO_OFF: begin acc_addr = 3'd3; acc_wr = 1'b1; end
            ERRCLR:  begin acc_addr = 3'd2; acc_wr = 1'b1; end
            WRDATA:  begin acc_addr = 3'd1; acc_wr = 1'b1; acc_wdata = {8'h00, tx_buf[idx]}; end
            POLL_T, POLL_R, POLL_E: acc_addr = 3'd2;
            default: acc_addr = 3'd0;
        endcase
    end

    // Bus window: phase 0/1 = select+strobe with addr/data stable, phase 2 = idle.
    // The core has no wait signal, so this fixed window is the whole handshake;
    // read data is taken at the end of phase 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            phase             <= 2'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 2'd0;
            idx               <= '0;
            len               <= '0;
            poll_cnt          <= '0;
            st_e              <= 1'b0;
            st_rrdy           <= 1'b0;
            st_trdy           <= 1'b0;
            st_tmt            <= 1'b0;
            spi_select        <= 1'b0;
            spi_mem_addr      <= 3'd0;
            spi_read_n        <= 1'b1;
            spi_write_n       <= 1'b1;
            spi_data_from_cpu <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 2'd0;
                        if (xfer_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len               <= len_clamped;
                            idx               <= '0;
                            busy              <= 1'b1;
                            poll_cnt          <= '0;
                            phase             <= 2'd0;
                            state             <= after_state;
                            spi_select        <= 1'b1;
                            spi_mem_addr      <= acc_addr;
                            spi_read_n        <= acc_wr;
                            spi_write_n       <= !acc_wr;
                            spi_data_from_cpu <= acc_wdata;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: begin
                    case (phase)
                        2'd0: phase <= 2'd1;
                        2'd1: begin
                            phase       <= 2'd2;
                            spi_select  <= 1'b0;
                            spi_read_n  <= 1'b1;
                            spi_write_n <= 1'b1;
                            st_e        <= spi_data_to_cpu[8];
                            st_rrdy     <= spi_data_to_cpu[7];
                            st_trdy     <= spi_data_to_cpu[6];
                            st_tmt      <= spi_data_to_cpu[5];
                        end
                        default: begin
                            phase    <= 2'd0;
                            err      <= after_err;
                            poll_cnt <= (after_state == state) ? poll_cnt + PW'(1) : '0;
                            if (state == RDDATA) idx <= idx + AW'(1);
                            if (after_state == FIN) begin
                                state <= FIN;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state             <= after_state;
                                spi_select        <= 1'b1;
                                spi_mem_addr      <= acc_addr;
                                spi_read_n        <= acc_wr;
                                spi_write_n       <= !acc_wr;
                                spi_data_from_cpu <= acc_wdata;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: behavioural SPI core register model, access log
// scoreboard against hand-built expected access sequences.
module tb_spi_xfer_sequencer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   xfer_len = '0;
    logic          tx_wr = 1'b0;
    logic [AW-1:0] tx_addr = '0;
    logic [7:0]    tx_data = 8'h00;
    logic [AW-1:0] rx_addr = '0;
    logic [7:0]    rx_data;
    logic          busy, done;
    logic [1:0]    err;
    logic          spi_select, spi_read_n, spi_write_n;
    logic [2:0]    spi_mem_addr;
    logic [15:0]   spi_data_from_cpu;
    logic [15:0]   spi_data_to_cpu = 16'h0000;

    spi_xfer_sequencer #(.DEPTH(16), .AW(AW), .POLL_LIMIT(4), .SS_MASK(16'h0001)) dut (
        .clk(clk), .reset(reset), .start(start), .xfer_len(xfer_len),
        .tx_wr(tx_wr), .tx_addr(tx_addr), .tx_data(tx_data),
        .rx_addr(rx_addr), .rx_data(rx_data),
        .busy(busy), .done(done), .err(err),
        .spi_select(spi_select), .spi_mem_addr(spi_mem_addr),
        .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
        .spi_data_from_cpu(spi_data_from_cpu), .spi_data_to_cpu(spi_data_to_cpu)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // scoreboard state: access entries are {is_write, addr[2:0], wdata[15:0]}
    logic [19:0] exp_q[$];
    logic [19:0] act_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // core model: 0 = always ready, 1 = E on first status read after a data write, 2 = never ready
    int          mode = 0;
    logic        e_pend = 1'b0;
    logic [7:0]  last_tx = 8'h00;
    logic [15:0] rd_val = 16'h0000;
    logic        sel_prev = 1'b0;
    int          run_len = 0;
    int          done_cnt = 0;
    int          n_wr1 = 0;
    int          n_rd0 = 0;
    logic        busy_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (spi_select && !spi_read_n) spi_data_to_cpu <= rd_val;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_seen = 1'b1;
        if (spi_select) begin
            run_len++;
        end else begin
            if (run_len != 0 && !reset) check("sel_len", 32'(run_len), 32'd2);
            run_len = 0;
        end
        if (spi_select && !sel_prev && !reset) begin
            act_q.push_back({!spi_write_n, spi_mem_addr, spi_write_n ? 16'h0000 : spi_data_from_cpu});
            if (!spi_write_n) begin
                if (spi_mem_addr == 3'd1) begin
                    last_tx = spi_data_from_cpu[7:0];
                    n_wr1++;
                    if (mode == 1) e_pend = 1'b1;
                end
            end else if (spi_mem_addr == 3'd2) begin
                if (e_pend) begin
                    rd_val = 16'h0100;
                    e_pend = 1'b0;
                end else if (mode == 2) begin
                    rd_val = 16'h0000;
                end else begin
                    rd_val = 16'h00E0;
                end
            end else if (spi_mem_addr == 3'd0) begin
                rd_val = {8'h00, last_tx};
                n_rd0++;
            end else begin
                rd_val = 16'h0000;
            end
        end
        sel_prev = spi_select;
    end

    // driver tasks (called at a negedge)
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input int a, input logic [7:0] d);
        tx_wr = 1'b1; tx_addr = AW'(a); tx_data = d;
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        start = 1'b1; xfer_len = (AW+1)'(len);
        @(negedge clk);
        start = 1'b0; xfer_len = '0;
    endtask

    task automatic set_mode(input int m);
        mode = m; e_pend = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic exp_w(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic exp_r(input logic [2:0] a);
        exp_q.push_back({1'b0, a, 16'h0000});
    endtask

    task automatic exp_open();
        exp_w(3'd5, 16'h0001);
        exp_w(3'd3, 16'h0400);
    endtask

    task automatic exp_byte(input logic [7:0] d);
        exp_r(3'd2); exp_w(3'd1, {8'h00, d}); exp_r(3'd2); exp_r(3'd0);
    endtask

    task automatic compare_acc(input string tag);
        check({tag, "_acc_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        while (exp_q.size() != 0 && act_q.size() != 0) begin
            logic [19:0] a;
            logic [19:0] e;
            a = act_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_acc"}, 32'(a), 32'(e));
        end
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic check_rx(input string tag, input int i, input logic [7:0] exp);
        rx_addr = AW'(i);
        #1;
        check(tag, 32'(rx_data), 32'(exp));
    endtask

    initial begin
        int d0;
        int found;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sel", 32'(spi_select), 32'd0);
        check("rst_rd_n", 32'(spi_read_n), 32'd1);
        check("rst_wr_n", 32'(spi_write_n), 32'd1);
        check("rst_addr", 32'(spi_mem_addr), 32'd0);
        check("rst_wdata", 32'(spi_data_from_cpu), 32'd0);
        reset = 1'b0;
        tick(1);

        // 3-byte loopback burst
        load_tx(0, 8'hA5); load_tx(1, 8'h3C); load_tx(2, 8'hFF);
        act_q.delete();
        exp_open(); exp_byte(8'hA5); exp_byte(8'h3C); exp_byte(8'hFF);
        exp_r(3'd2); exp_w(3'd3, 16'h0000);
        d0 = done_cnt;
        pulse_start(3);
        check("lb_busy", 32'(busy), 32'd1);
        wait_done("lb", 400);
        check("lb_err", 32'(err), 32'd0);
        tick(3);
        check("lb_done_cnt", 32'(done_cnt - d0), 32'd1);
        compare_acc("lb");
        check_rx("lb_rx0", 0, 8'hA5);
        check_rx("lb_rx1", 1, 8'h3C);
        check_rx("lb_rx2", 2, 8'hFF);

        // core error on the first RRDY poll
        set_mode(1);
        exp_open(); exp_r(3'd2); exp_w(3'd1, 16'h00A5); exp_r(3'd2);
        exp_w(3'd2, 16'h0000); exp_w(3'd3, 16'h0000);
        d0 = done_cnt;
        pulse_start(1);
        wait_done("eerr", 200);
        tick(3);
        check("eerr_err", 32'(err), 32'd2);
        check("eerr_done_cnt", 32'(done_cnt - d0), 32'd1);
        compare_acc("eerr");

        // TRDY never set: POLL_LIMIT (4) status reads then timeout
        set_mode(2);
        exp_open(); exp_r(3'd2); exp_r(3'd2); exp_r(3'd2); exp_r(3'd2);
        exp_w(3'd2, 16'h0000); exp_w(3'd3, 16'h0000);
        d0 = done_cnt;
        pulse_start(2);
        wait_done("tmo", 200);
        tick(3);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_done_cnt", 32'(done_cnt - d0), 32'd1);
        compare_acc("tmo");

        // empty transaction also clears the latched error
        set_mode(0);
        busy_seen = 1'b0;
        d0 = done_cnt;
        pulse_start(0);
        check("z_done", 32'(done), 32'd1);
        check("z_busy", 32'(busy), 32'd0);
        check("z_err", 32'(err), 32'd0);
        tick(4);
        check("z_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("z_busy_seen", 32'(busy_seen), 32'd0);
        compare_acc("z");

        // tx_wr and start while busy are dropped
        load_tx(0, 8'h11);
        exp_open(); exp_byte(8'h11); exp_r(3'd2); exp_w(3'd3, 16'h0000);
        d0 = done_cnt;
        pulse_start(1);
        tick(3);
        tx_wr = 1'b1; tx_addr = '0; tx_data = 8'h99;
        start = 1'b1; xfer_len = (AW+1)'(1);
        @(negedge clk);
        tx_wr = 1'b0; start = 1'b0; xfer_len = '0;
        wait_done("busy", 200);
        tick(6);
        check("busy_done_cnt", 32'(done_cnt - d0), 32'd1);
        compare_acc("busy");
        exp_open(); exp_byte(8'h11); exp_r(3'd2); exp_w(3'd3, 16'h0000);
        pulse_start(1);
        wait_done("busy2", 200);
        tick(3);
        compare_acc("busy2");

        // xfer_len above DEPTH clamps to 16 bytes
        for (int i = 0; i < 16; i++) load_tx(i, 8'(i * 17 + 3));
        act_q.delete();
        exp_open();
        for (int i = 0; i < 16; i++) exp_byte(8'(i * 17 + 3));
        exp_r(3'd2); exp_w(3'd3, 16'h0000);
        n_wr1 = 0; n_rd0 = 0;
        d0 = done_cnt;
        pulse_start(20);
        wait_done("clamp", 2000);
        tick(3);
        check("clamp_wr", 32'(n_wr1), 32'd16);
        check("clamp_rd", 32'(n_rd0), 32'd16);
        check("clamp_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("clamp_err", 32'(err), 32'd0);
        compare_acc("clamp");
        check_rx("clamp_rx0", 0, 8'h03);
        check_rx("clamp_rx7", 7, 8'h7A);
        check_rx("clamp_rx15", 15, 8'h02);

        // reset in the middle of the WRDATA access
        pulse_start(1);
        found = 0;
        for (int n = 0; n < 60 && found == 0; n++) begin
            if (spi_select && !spi_write_n && spi_mem_addr == 3'd1) found = 1;
            else @(negedge clk);
        end
        check("mid_wrdata_seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_sel", 32'(spi_select), 32'd0);
        check("mid_rd_n", 32'(spi_read_n), 32'd1);
        check("mid_wr_n", 32'(spi_write_n), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        tick(1);
        reset = 1'b0;
        set_mode(0);
        tick(2);
        act_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
